// File: rtl/sdram_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdram_sched : SDRAM command-port arbiter for video refill, writeback, fill   |
// | Revision    : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module sdram_sched #(
  parameter int          VID_WORDS   = 3072,
  parameter logic [14:0] VID_BASE    = 15'h6ff8,
  parameter int          VID_BEATS   = 16,
  parameter int          LINE_BEATS  = 128,
  parameter int          MAX_VID_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        vid_empty,
  input  logic        vsync,
  input  logic        wb_req,
  input  logic [11:0] wb_addr,
  input  logic        fill_req,
  input  logic [11:0] fill_addr,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_valid,
  input  logic        sys_wr_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_wdata,
  output logic        cache_rdata,
  output logic [31:0] vid_data,
  output logic        vid_wen,
  output logic [11:0] vid_line,
  output logic        busy
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_xfer  = 2'd2;

  localparam logic [1:0] c_cmd_nop  = 2'b00;
  localparam logic [1:0] c_cmd_wr   = 2'b01;
  localparam logic [1:0] c_cmd_vid  = 2'b10;
  localparam logic [1:0] c_cmd_fill = 2'b11;

  localparam logic [2:0]  c_run_max  = 3'(MAX_VID_RUN);
  localparam logic [11:0] c_line_max = 12'(VID_WORDS - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  sys_cmd_q, sys_cmd_d;
  logic [17:0] sys_addr_q, sys_addr_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  beat_q, beat_d;
  logic [2:0]  run_q, run_d;
  logic        phase_q, phase_d;
  logic [15:0] low_q, low_d;
  logic [31:0] vid_data_q, vid_data_d;
  logic        vid_wen_q, vid_wen_d;
  logic [11:0] vid_line_q, vid_line_d;
  logic        vs_meta_q, vs_sync_q, vs_prev_q;
  logic        pend_q, pend_d;

  logic        w_idle, w_issue, w_xfer;
  logic        w_cache_pend, w_guard;
  logic        w_gnt_vid, w_gnt_wb, w_gnt_fill;
  logic        w_ack_match, w_own_beat, w_last_beat;
  logic        w_vs_rise, w_resync;
  logic [11:0] w_line_eff;
  logic [14:0] w_vid_off, w_vid_sum;
  logic [17:0] w_vid_addr;

  assign w_idle  = (state_q == c_st_idle);
  assign w_issue = (state_q == c_st_issue);
  assign w_xfer  = (state_q == c_st_xfer);

  // A pending cache request that has waited MAX_VID_RUN video bursts takes the
  // port, unless the video FIFO has fully drained.
  assign w_cache_pend = wb_req | fill_req;
  assign w_guard      = w_cache_pend && (run_q == c_run_max) && !vid_empty;
  assign w_gnt_vid    = w_idle && vid_low && !w_guard;
  assign w_gnt_wb     = w_idle && !w_gnt_vid && wb_req;
  assign w_gnt_fill   = w_idle && !w_gnt_vid && !wb_req && fill_req;

  assign w_ack_match  = w_issue && (sys_cmd_ack == sys_cmd_q);
  assign w_own_beat   = w_xfer && ((owner_q == c_cmd_wr) ? sys_wr_valid : sys_rd_valid);
  assign w_last_beat  = w_own_beat && (beat_q == 8'd1);

  assign w_vs_rise  = vs_sync_q & ~vs_prev_q;
  assign w_resync   = w_idle && (pend_q || w_vs_rise);
  assign w_line_eff = w_resync ? 12'd0 : vid_line_q;

  // Line index is scrambled into the framebuffer offset; the 15-bit add drops carry.
  assign w_vid_off  = {3'b000, ~w_line_eff[11:2], w_line_eff[1:0]};
  assign w_vid_sum  = VID_BASE + w_vid_off;
  assign w_vid_addr = {w_vid_sum, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (w_gnt_vid || w_gnt_wb || w_gnt_fill) state_d = c_st_issue;
      c_st_issue: if (w_ack_match) state_d = c_st_xfer;
      c_st_xfer:  if (w_last_beat) state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  always_comb begin
    busy        = !w_idle;
    cache_wdata = w_xfer && (owner_q == c_cmd_fill) && sys_rd_valid;
    cache_rdata = w_xfer && (owner_q == c_cmd_wr) && sys_wr_valid;
  end

  always_comb begin
    sys_cmd_d  = sys_cmd_q;
    sys_addr_d = sys_addr_q;
    owner_d    = owner_q;
    beat_d     = beat_q;
    run_d      = run_q;
    phase_d    = phase_q;
    low_d      = low_q;
    vid_data_d = vid_data_q;
    vid_wen_d  = 1'b0;
    vid_line_d = vid_line_q;
    pend_d     = pend_q;

    if (!w_cache_pend || w_gnt_wb || w_gnt_fill) begin
      run_d = 3'd0;
    end else if (w_gnt_vid && (run_q != c_run_max)) begin
      run_d = run_q + 3'd1;
    end

    if (w_gnt_vid) begin
      sys_cmd_d  = c_cmd_vid;
      sys_addr_d = w_vid_addr;
    end else if (w_gnt_wb) begin
      sys_cmd_d  = c_cmd_wr;
      sys_addr_d = {wb_addr, 6'b0};
    end else if (w_gnt_fill) begin
      sys_cmd_d  = c_cmd_fill;
      sys_addr_d = {fill_addr, 6'b0};
    end

    if (w_ack_match) begin
      sys_cmd_d = c_cmd_nop;
      owner_d   = sys_cmd_q;
      phase_d   = 1'b0;
      beat_d    = (sys_cmd_q == c_cmd_vid) ? 8'(VID_BEATS) : 8'(LINE_BEATS);
    end

    if (w_own_beat) begin
      beat_d = beat_q - 8'd1;
      if (owner_q == c_cmd_vid) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          low_d = sys_dout;
        end else begin
          vid_data_d = {sys_dout, low_q};
          vid_wen_d  = 1'b1;
        end
      end
    end

    // An ack increment in ISSUE lands first; a pending resync waits for IDLE.
    if (w_resync) begin
      vid_line_d = 12'd0;
      pend_d     = 1'b0;
    end else begin
      if (w_vs_rise) pend_d = 1'b1;
      if (w_ack_match && (sys_cmd_q == c_cmd_vid)) begin
        vid_line_d = (vid_line_q == c_line_max) ? 12'd0 : vid_line_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cmd_q  <= c_cmd_nop;
      sys_addr_q <= 18'd0;
      owner_q    <= c_cmd_nop;
      beat_q     <= 8'd0;
      run_q      <= 3'd0;
      phase_q    <= 1'b0;
      low_q      <= 16'd0;
      vid_data_q <= 32'd0;
      vid_wen_q  <= 1'b0;
      vid_line_q <= 12'd0;
      vs_meta_q  <= 1'b0;
      vs_sync_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      sys_cmd_q  <= sys_cmd_d;
      sys_addr_q <= sys_addr_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      run_q      <= run_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      vid_data_q <= vid_data_d;
      vid_wen_q  <= vid_wen_d;
      vid_line_q <= vid_line_d;
      vs_meta_q  <= vsync;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
      pend_q     <= pend_d;
    end
  end

  assign sys_cmd  = sys_cmd_q;
  assign sys_addr = sys_addr_q;
  assign vid_data = vid_data_q;
  assign vid_wen  = vid_wen_q;
  assign vid_line = vid_line_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_sched.sv
`default_nettype none
// Directed vector bench for sdram_sched: arbitration table plus multi-cycle sequences.
module tb_sdram_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vid_low = 1'b0, vid_empty = 1'b0, vsync = 1'b0;
  logic        wb_req = 1'b0, fill_req = 1'b0;
  logic [11:0] wb_addr = '0, fill_addr = '0;
  logic [1:0]  sys_cmd_ack = '0;
  logic        sys_rd_valid = 1'b0, sys_wr_valid = 1'b0;
  logic [15:0] sys_dout = '0;

  logic [1:0]  sys_cmd, s_sys_cmd;
  logic [17:0] sys_addr, s_sys_addr;
  logic        cache_wdata, cache_rdata, vid_wen, busy;
  logic        s_cache_wdata, s_cache_rdata, s_vid_wen, s_busy;
  logic [31:0] vid_data, s_vid_data;
  logic [11:0] vid_line, s_vid_line;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_sched u_dut (
    .clk(clk), .rst(rst), .vid_low(vid_low), .vid_empty(vid_empty), .vsync(vsync),
    .wb_req(wb_req), .wb_addr(wb_addr), .fill_req(fill_req), .fill_addr(fill_addr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_valid(sys_rd_valid), .sys_wr_valid(sys_wr_valid), .sys_dout(sys_dout),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .vid_data(vid_data),
    .vid_wen(vid_wen), .vid_line(vid_line), .busy(busy)
  );

  // Small frame so the line counter wrap can be reached quickly.
  sdram_sched #(.VID_WORDS(6)) u_small (
    .clk(clk), .rst(rst), .vid_low(vid_low), .vid_empty(vid_empty), .vsync(vsync),
    .wb_req(wb_req), .wb_addr(wb_addr), .fill_req(fill_req), .fill_addr(fill_addr),
    .sys_cmd(s_sys_cmd), .sys_addr(s_sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_valid(sys_rd_valid), .sys_wr_valid(sys_wr_valid), .sys_dout(sys_dout),
    .cache_wdata(s_cache_wdata), .cache_rdata(s_cache_rdata), .vid_data(s_vid_data),
    .vid_wen(s_vid_wen), .vid_line(s_vid_line), .busy(s_busy)
  );

  typedef struct {
    logic        vl, ve, wb, fl;
    logic [11:0] wa, fa;
    logic [1:0]  cmd;
    logic [17:0] addr;
    logic        bsy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vid_low = 0; vid_empty = 0; vsync = 0; wb_req = 0; fill_req = 0;
    wb_addr = '0; fill_addr = '0; sys_cmd_ack = '0;
    sys_rd_valid = 0; sys_wr_valid = 0; sys_dout = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Acks a pending video command and feeds 16 beats of 16'h1111*(n+1).
  task automatic vid_xfer(output int wen_cnt, output logic [31:0] first_word);
    logic [15:0] b;
    wen_cnt = 0;
    first_word = '0;
    sys_cmd_ack = 2'b10;
    step();
    sys_cmd_ack = 2'b00;
    for (int i = 0; i < 16; i++) begin
      b = 16'h1111 * 16'(i + 1);
      sys_rd_valid = 1'b1;
      sys_dout = b;
      step();
      if (vid_wen) begin
        if (wen_cnt == 0) first_word = vid_data;
        wen_cnt++;
      end
    end
    sys_rd_valid = 1'b0;
  endtask

  task automatic line_xfer(input logic [1:0] cmd, input logic wr, output int strobes);
    strobes = 0;
    sys_cmd_ack = cmd;
    step();
    sys_cmd_ack = 2'b00;
    for (int i = 0; i < 128; i++) begin
      if (wr) sys_wr_valid = 1'b1;
      else    sys_rd_valid = 1'b1;
      #1;
      if (wr ? cache_rdata : cache_wdata) strobes++;
      step();
    end
    sys_wr_valid = 1'b0;
    sys_rd_valid = 1'b0;
  endtask

  task automatic guard_run(input logic empty, input logic [1:0] exp_cmd,
                           input logic [17:0] exp_addr, input string tag);
    int          wc;
    logic [31:0] fw;
    do_reset();
    vid_low = 1; fill_req = 1; fill_addr = 12'h0f0; vid_empty = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("%s_vid_grant%0d", tag, k), 32'(sys_cmd), 32'h2);
      vid_xfer(wc, fw);
    end
    check({tag, "_line4"}, 32'(vid_line), 32'd4);
    vid_empty = empty;
    step();
    check({tag, "_cmd5"}, 32'(sys_cmd), 32'(exp_cmd));
    check({tag, "_addr5"}, 32'(sys_addr), 32'(exp_addr));
  endtask

  initial begin
    int          wc, sc;
    logic [31:0] fw;

    vecs[0] = '{1, 0, 1, 1, 12'h011, 12'h022, 2'b10, 18'h3ffa0, 1};
    vecs[1] = '{0, 0, 1, 1, 12'h123, 12'habc, 2'b01, 18'h048c0, 1};
    vecs[2] = '{0, 0, 0, 1, 12'h123, 12'habc, 2'b11, 18'h2af00, 1};
    vecs[3] = '{0, 0, 0, 0, 12'h123, 12'habc, 2'b00, 18'h00000, 0};
    vecs[4] = '{1, 1, 0, 0, 12'h000, 12'h000, 2'b10, 18'h3ffa0, 1};
    vecs[5] = '{0, 1, 1, 0, 12'hfff, 12'h001, 2'b01, 18'h3ffc0, 1};

    // Reset state, sampled while reset is held.
    rst = 1'b0;
    #12;
    check("rst_cmd", 32'(sys_cmd), 32'h0);
    check("rst_addr", 32'(sys_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_line", 32'(vid_line), 32'h0);
    check("rst_vdata", vid_data, 32'h0);
    check("rst_strobes", {29'd0, vid_wen, cache_wdata, cache_rdata}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      vid_low = vecs[i].vl; vid_empty = vecs[i].ve;
      wb_req = vecs[i].wb; fill_req = vecs[i].fl;
      wb_addr = vecs[i].wa; fill_addr = vecs[i].fa;
      step();
      check($sformatf("vec%0d_cmd", i), 32'(sys_cmd), 32'(vecs[i].cmd));
      check($sformatf("vec%0d_addr", i), 32'(sys_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
    end

    // Video, then writeback, then fill; ack mismatch ignored; extra beat dropped.
    do_reset();
    vid_low = 1; wb_req = 1; fill_req = 1; wb_addr = 12'h011; fill_addr = 12'h022;
    step();
    check("seq_vid_cmd", 32'(sys_cmd), 32'h2);
    vid_low = 0;
    vid_xfer(wc, fw);
    check("seq_vid_wen_count", 32'(wc), 32'd8);
    check("seq_vid_first_word", fw, 32'h2222_1111);
    check("seq_vid_line", 32'(vid_line), 32'd1);
    step();
    check("seq_wb_cmd", 32'(sys_cmd), 32'h1);
    check("seq_wb_addr", 32'(sys_addr), 32'h00440);
    wb_req = 0;
    sys_cmd_ack = 2'b10;
    step();
    check("seq_ack_mismatch_cmd", 32'(sys_cmd), 32'h1);
    check("seq_ack_mismatch_busy", 32'(busy), 32'h1);
    line_xfer(2'b01, 1'b1, sc);
    check("seq_wb_strobes", 32'(sc), 32'd128);
    step();
    check("seq_fill_cmd", 32'(sys_cmd), 32'h3);
    check("seq_fill_addr", 32'(sys_addr), 32'h00880);
    fill_req = 0;
    line_xfer(2'b11, 1'b0, sc);
    check("seq_fill_strobes", 32'(sc), 32'd128);
    check("seq_fill_busy_end", 32'(busy), 32'h0);
    sys_rd_valid = 1;
    #1;
    check("seq_beat129_wdata", 32'(cache_wdata), 32'h0);
    step();
    sys_rd_valid = 0;
    check("seq_beat129_busy", 32'(busy), 32'h0);

    // Starvation guard, and vid_empty overriding it.
    guard_run(1'b0, 2'b11, 18'h03c00, "guard");
    guard_run(1'b1, 2'b10, 18'h3ff80, "empty");

    // Line counter wrap (6-word frame on u_small) and address at line 6 on u_dut.
    do_reset();
    vid_low = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      vid_xfer(wc, fw);
    end
    check("wrap_small_line", 32'(s_vid_line), 32'd0);
    check("wrap_main_line", 32'(vid_line), 32'd6);
    step();
    check("wrap_small_addr", 32'(s_sys_addr), 32'h3ffa0);
    check("wrap_main_addr", 32'(sys_addr), 32'h3ff90);

    // Frame resync during a video transfer clears the line at the next IDLE.
    do_reset();
    vid_low = 1;
    step();
    vsync = 1;
    vid_xfer(wc, fw);
    step();
    check("vsync_line", 32'(vid_line), 32'd0);
    check("vsync_cmd", 32'(sys_cmd), 32'h2);
    check("vsync_addr", 32'(sys_addr), 32'h3ffa0);
    vsync = 0;

    // Asynchronous reset in the middle of a video transfer.
    do_reset();
    vid_low = 1;
    step();
    sys_cmd_ack = 2'b10;
    step();
    sys_cmd_ack = 2'b00;
    sys_rd_valid = 1; sys_dout = 16'h1234;
    step();
    step();
    check("midx_busy", 32'(busy), 32'h1);
    check("midx_line", 32'(vid_line), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cmd", 32'(sys_cmd), 32'h0);
    check("arst_line", 32'(vid_line), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b1;
    vid_low = 0; sys_rd_valid = 0; fill_req = 1; fill_addr = 12'h055;
    step();
    check("post_rst_cmd", 32'(sys_cmd), 32'h3);
    check("post_rst_addr", 32'(sys_addr), 32'h01540);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
